adc_trigger: RTL

Analog trigger detector between the ADC input register and the ADC capture driver.
- Watches one selected 8-bit ADC channel at the decimated sample rate.
- Applies level, slope and hysteresis qualification, an auto-timeout and a holdoff.
- Produces the `trigger_req` pulse the capture driver consumes.
- Configuration comes from a 32-bit word written by the MCU over SPI.

---
 rtl/adc_trigger_pkg.sv | 81 ++++++++
 rtl/adc_trigger_compare.sv | 48 ++++
 rtl/adc_trigger.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/adc_trigger_pkg.sv
// -----------------------------------------------------------------------------
// adc_trigger_pkg
//   Shared definitions for the analog trigger detector:
//   - trig_state_e : 2-bit status encoding driven on trig_state
//   - fsm_state_e  : internal FSM states (FIRE is distinct internally)
//   - trig_mode_e  : trigger modes carried in the configuration word
//   - CFG_* field positions of the 32-bit configuration word, shared with
//     the SPI configuration module
//   - trig_cfg_t   : unpacked view of the configuration word
// -----------------------------------------------------------------------------
package adc_trigger_pkg;

    // Status encoding seen on trig_state.
    typedef enum logic [1:0] {
        TS_IDLE  = 2'd0,
        TS_ARMED = 2'd1,
        TS_WAIT  = 2'd2,
        TS_HOLD  = 2'd3
    } trig_state_e;

    // Internal FSM states. FIRE reports as HOLD on the status port.
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_WAIT,
        S_FIRE,
        S_HOLD
    } fsm_state_e;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_NORMAL = 2'd1,
        MODE_AUTO   = 2'd2,
        MODE_SINGLE = 2'd3
    } trig_mode_e;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    // Configuration word field positions.
    localparam int CFG_LEVEL_LSB   = 0;
    localparam int CFG_LEVEL_W     = 8;
    localparam int CFG_HYST_LSB    = 8;
    localparam int CFG_HYST_W      = 4;
    localparam int CFG_SRC_BIT     = 12;
    localparam int CFG_SLOPE_BIT   = 13;
    localparam int CFG_MODE_LSB    = 14;
    localparam int CFG_MODE_W      = 2;
    localparam int CFG_HOLDOFF_LSB = 16;
    localparam int CFG_HOLDOFF_W   = 16;

    typedef struct packed {
        logic [CFG_HOLDOFF_W-1:0] holdoff;
        trig_mode_e               mode;
        logic                     slope;
        logic                     src;
        logic [CFG_HYST_W-1:0]    hyst;
        logic [CFG_LEVEL_W-1:0]   level;
    } trig_cfg_t;

    function automatic trig_cfg_t unpack_cfg(input logic [31:0] word);
        trig_cfg_t c;
        c.level   = word[CFG_LEVEL_LSB +: CFG_LEVEL_W];
        c.hyst    = word[CFG_HYST_LSB +: CFG_HYST_W];
        c.src     = word[CFG_SRC_BIT];
        c.slope   = word[CFG_SLOPE_BIT];
        c.mode    = trig_mode_e'(word[CFG_MODE_LSB +: CFG_MODE_W]);
        c.holdoff = word[CFG_HOLDOFF_LSB +: CFG_HOLDOFF_W];
        return c;
    endfunction

    function automatic trig_state_e status_of(input fsm_state_e s);
        case (s)
            S_ARMED:        return TS_ARMED;
            S_WAIT:         return TS_WAIT;
            S_FIRE, S_HOLD: return TS_HOLD;
            default:        return TS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/adc_trigger_compare.sv
// -----------------------------------------------------------------------------
// trig_compare
//   Combinational threshold unit. Derives the hysteresis pre-threshold from
//   level/hyst with 9-bit saturating arithmetic and qualifies a sample.
// Ports:
//   sample  in  8  registered ADC sample
//   level   in  8  trigger level
//   hyst    in  4  hysteresis width
//   slope   in  1  0 = rising, 1 = falling
//   arm_ok  out 1  sample is on the far side of the pre-threshold
//   fire_ok out 1  sample has reached the trigger level
// -----------------------------------------------------------------------------
module trig_compare
    import adc_trigger_pkg::*;
(
    input  logic [7:0] sample,
    input  logic [7:0] level,
    input  logic [3:0] hyst,
    input  logic       slope,
    output logic       arm_ok,
    output logic       fire_ok
);

    logic [8:0] lo9;
    logic [8:0] hi9;
    logic [7:0] pre;

    // Ninth bit is the borrow (rising) or carry (falling) used for saturation.
    assign lo9 = {1'b0, level} - {5'b0, hyst};
    assign hi9 = {1'b0, level} + {5'b0, hyst};

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        pre     = level;
        arm_ok  = 1'b0;
        fire_ok = 1'b0;
        if (slope == SLOPE_RISE) begin
            pre     = lo9[8] ? 8'd0 : lo9[7:0];
            arm_ok  = (sample <= pre);
            fire_ok = (sample >= level);
        end else begin
            pre     = hi9[8] ? 8'd255 : hi9[7:0];
            arm_ok  = (sample >= pre);
            fire_ok = (sample <= level);
        end
    end

endmodule

// File: rtl/adc_trigger.sv
// -----------------------------------------------------------------------------
// adc_trigger
//   Analog trigger detector. Watches one ADC channel at the decimated sample
//   rate and issues a one-cycle trigger_req after level/slope/hysteresis
//   qualification, an auto-timeout or an MCU force, followed by a holdoff.
// Parameters:
//   AUTO_W  width of the auto-trigger timeout counter (clk cycles)
//   HOLD_W  width of the holdoff counter (samples)
// Ports:
//   clk          in  1   sample clock
//   rst          in  1   synchronous active-high reset
//   sample_en    in  1   adc_a/adc_b hold a new sample this cycle
//   adc_a        in  8   channel A sample
//   adc_b        in  8   channel B sample
//   cfg          in  32  configuration word, latched on IDLE->ARMED
//   enable       in  1   capture driver is waiting for a trigger
//   force_trig   in  1   one-cycle force request
//   trigger_req  out 1   one-cycle trigger pulse
//   trig_state   out 2   FSM status (IDLE/ARMED/WAIT/HOLD)
//   auto_fired   out 1   last trigger came from timeout or force
// -----------------------------------------------------------------------------
module adc_trigger
    import adc_trigger_pkg::*;
#(
    parameter int AUTO_W = 24,
    parameter int HOLD_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic [7:0]  adc_a,
    input  logic [7:0]  adc_b,
    input  logic [31:0] cfg,
    input  logic        enable,
    input  logic        force_trig,
    output logic        trigger_req,
    output logic [1:0]  trig_state,
    output logic        auto_fired
);

    localparam logic [AUTO_W-1:0] AUTO_MAX  = '1;
    // Moving to FIRE on the cycle the counter steps to its maximum makes the
    // trigger land exactly 2^AUTO_W-1 cycles after ARMED entry.
    localparam logic [AUTO_W-1:0] AUTO_LAST = {{(AUTO_W-1){1'b1}}, 1'b0};

    fsm_state_e        state;
    trig_cfg_t         cfg_q;
    trig_cfg_t         cfg_in;
    logic [7:0]        a_q;
    logic [7:0]        b_q;
    logic              smp_vld;
    logic [AUTO_W-1:0] auto_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] holdoff_len;
    logic              single_lock;

    logic [7:0]        cur_sample;
    logic              arm_ok;
    logic              fire_ok;

    logic              go_abort;
    logic              go_fire;
    logic              fire_is_auto;
    logic              go_wait;

    assign cfg_in      = unpack_cfg(cfg);
    assign cur_sample  = cfg_q.src ? b_q : a_q;
    assign holdoff_len = HOLD_W'(cfg_q.holdoff);
    assign trig_state  = status_of(state);

    trig_compare u_cmp (
        .sample  (cur_sample),
        .level   (cfg_q.level),
        .hyst    (cfg_q.hyst),
        .slope   (cfg_q.slope),
        .arm_ok  (arm_ok),
        .fire_ok (fire_ok)
    );

    // Event arbitration while waiting for a trigger:
    // enable drop > force > level fire > auto timeout > arming.
    always_comb begin
        go_abort     = 1'b0;
        go_fire      = 1'b0;
        fire_is_auto = 1'b0;
        go_wait      = 1'b0;
        if (state == S_ARMED || state == S_WAIT) begin
            if (!enable) begin
                go_abort = 1'b1;
            end else if (force_trig) begin
                go_fire      = 1'b1;
                fire_is_auto = 1'b1;
            end else if (state == S_WAIT && smp_vld && fire_ok) begin
                go_fire = 1'b1;
            end else if (cfg_q.mode == MODE_AUTO && auto_cnt == AUTO_LAST) begin
                go_fire      = 1'b1;
                fire_is_auto = 1'b1;
            end else if (state == S_ARMED && smp_vld && arm_ok) begin
                // A sample meeting both conditions only arms; the fire must
                // come from a later sample so a real edge is seen.
                go_wait = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cfg_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            smp_vld     <= 1'b0;
            auto_cnt    <= '0;
            hold_cnt    <= '0;
            single_lock <= 1'b0;
            trigger_req <= 1'b0;
            auto_fired  <= 1'b0;
        end else begin
            trigger_req <= 1'b0;
            smp_vld     <= sample_en;
            if (sample_en) begin
                a_q <= adc_a;
                b_q <= adc_b;
            end

            if (!enable) begin
                single_lock <= 1'b0;
            end

            // Timeout counter runs in ARMED and WAIT and saturates.
            if ((state == S_ARMED || state == S_WAIT) && auto_cnt != AUTO_MAX) begin
                auto_cnt <= auto_cnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (enable && cfg_in.mode != MODE_OFF && !single_lock) begin
                        cfg_q    <= cfg_in;
                        auto_cnt <= '0;
                        state    <= S_ARMED;
                    end
                end

                S_ARMED, S_WAIT: begin
                    if (go_abort) begin
                        state <= S_IDLE;
                    end else if (go_fire) begin
                        state       <= S_FIRE;
                        trigger_req <= 1'b1;
                        auto_fired  <= fire_is_auto;
                        hold_cnt    <= '0;
                    end else if (go_wait) begin
                        state <= S_WAIT;
                    end
                end

                S_FIRE: begin
                    state <= S_HOLD;
                end

                S_HOLD: begin
                    if (hold_cnt == holdoff_len) begin
                        state <= S_IDLE;
                        // Single mode waits for an enable toggle before re-arming.
                        if (cfg_q.mode == MODE_SINGLE) begin
                            single_lock <= 1'b1;
                        end
                    end else if (sample_en) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
